// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: a pixel-enable divider, h/v raster counters and
// registered sync, data-enable, character-cell coordinates and line/frame start pulses.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CLK_DIV  = 4,
   parameter int CHAR_W   = 8,
   parameter int CHAR_H   = 16,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL),
   localparam int CCW     = (H_ACTIVE / CHAR_W > 1) ? $clog2(H_ACTIVE / CHAR_W) : 1,
   localparam int CRW     = (V_ACTIVE / CHAR_H > 1) ? $clog2(V_ACTIVE / CHAR_H) : 1,
   localparam int GXW     = (CHAR_W > 1) ? $clog2(CHAR_W) : 1,
   localparam int GYW     = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic           pix_en,
   output logic [HW-1:0]  h_cnt,
   output logic [VW-1:0]  v_cnt,
   output logic           de,
   output logic           hsync,
   output logic           vsync,
   output logic [CCW-1:0] char_col,
   output logic [CRW-1:0] char_row,
   output logic [GXW-1:0] glyph_x,
   output logic [GYW-1:0] glyph_y,
   output logic           line_start,
   output logic           frame_start
);

   localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW_SH = $clog2(CHAR_W);
   localparam int CH_SH = $clog2(CHAR_H);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_GMASK = HW'(CHAR_W - 1);

   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_GMASK = VW'(CHAR_H - 1);

   logic [DW-1:0]  div;
   logic           tick;
   logic           h_wrap;
   logic [HW-1:0]  h_nxt;
   logic [VW-1:0]  v_nxt;
   logic           de_nxt;
   logic           hs_act;
   logic           vs_act;
   logic [CCW-1:0] col_nxt;
   logic [CRW-1:0] row_nxt;
   logic [GXW-1:0] gx_nxt;
   logic [GYW-1:0] gy_nxt;

   // Pixel-enable divider: with CLK_DIV=1 div stays 0 and every enabled cycle ticks.
   assign tick = en && (div == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (!en || tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Next raster position and everything decoded from it, so registered outputs line up with the counters.
   always_comb begin
      h_wrap  = (h_cnt == H_LAST);
      h_nxt   = h_wrap ? '0 : h_cnt + 1'b1;
      v_nxt   = v_cnt;
      if (h_wrap) begin
         v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
      de_nxt  = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hs_act  = (h_nxt >= H_SS) && (h_nxt < H_SE);
      vs_act  = (v_nxt >= V_SS) && (v_nxt < V_SE);
      col_nxt = CCW'(h_nxt >> CW_SH);
      row_nxt = CRW'(v_nxt >> CH_SH);
      gx_nxt  = GXW'(h_nxt & H_GMASK);
      gy_nxt  = GYW'(v_nxt & V_GMASK);
   end

   // Pulses follow the registered tick; everything else only moves on a tick edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_en      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         h_cnt       <= H_LAST;
         v_cnt       <= V_LAST;
         de          <= 1'b0;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         char_col    <= '0;
         char_row    <= '0;
         glyph_x     <= '0;
         glyph_y     <= '0;
      end else begin
         pix_en      <= tick;
         line_start  <= tick && (h_nxt == '0);
         frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
         if (tick) begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            de       <= de_nxt;
            hsync    <= hs_act ? H_POL : ~H_POL;
            vsync    <= vs_act ? V_POL : ~V_POL;
            char_col <= de_nxt ? col_nxt : '0;
            char_row <= de_nxt ? row_nxt : '0;
            glyph_x  <= de_nxt ? gx_nxt : '0;
            glyph_y  <= de_nxt ? gy_nxt : '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, small and divide-by-1 active-high instances
// share one clock and reset; expected values are hand-derived from cycle counts.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic rst, en_def, en_sm, en_fast;
   int   cyc, n_cmp, n_err;

   // default configuration
   logic       d_pix, d_de, d_hs, d_vs, d_ls, d_fs;
   logic [9:0] d_h, d_v;
   logic [6:0] d_cc;
   logic [4:0] d_cr;
   logic [2:0] d_gx;
   logic [3:0] d_gy;

   // small configuration
   logic       s_pix, s_de, s_hs, s_vs, s_ls, s_fs;
   logic [2:0] s_h, s_v;
   logic [0:0] s_cc;
   logic [1:0] s_cr;
   logic [0:0] s_gx;
   logic [0:0] s_gy;

   // CLK_DIV=1, active-high syncs
   logic       f_pix, f_de, f_hs, f_vs, f_ls, f_fs;
   logic [9:0] f_h, f_v;
   logic [6:0] f_cc;
   logic [4:0] f_cr;
   logic [2:0] f_gx;
   logic [3:0] f_gy;

   vga_timing_gen u_def (
      .clk(clk), .rst(rst), .en(en_def), .pix_en(d_pix), .h_cnt(d_h), .v_cnt(d_v),
      .de(d_de), .hsync(d_hs), .vsync(d_vs), .char_col(d_cc), .char_row(d_cr),
      .glyph_x(d_gx), .glyph_y(d_gy), .line_start(d_ls), .frame_start(d_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(2), .CHAR_W(2), .CHAR_H(1)
   ) u_sm (
      .clk(clk), .rst(rst), .en(en_sm), .pix_en(s_pix), .h_cnt(s_h), .v_cnt(s_v),
      .de(s_de), .hsync(s_hs), .vsync(s_vs), .char_col(s_cc), .char_row(s_cr),
      .glyph_x(s_gx), .glyph_y(s_gy), .line_start(s_ls), .frame_start(s_fs)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_POL(1'b1), .V_POL(1'b1)
   ) u_fast (
      .clk(clk), .rst(rst), .en(en_fast), .pix_en(f_pix), .h_cnt(f_h), .v_cnt(f_v),
      .de(f_de), .hsync(f_hs), .vsync(f_vs), .char_col(f_cc), .char_row(f_cr),
      .glyph_x(f_gx), .glyph_y(f_gy), .line_start(f_ls), .frame_start(f_fs)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Releases reset just after an edge, then checks the first edges of all three instances.
   task automatic release_checks();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      step();
      chk("def_pix_e1", 32'(d_pix), 32'd0);
      chk("def_hs_e1", 32'(d_hs), 32'd1);
      chk("def_vs_e1", 32'(d_vs), 32'd1);
      chk("fast_pix_e1", 32'(f_pix), 32'd1);
      chk("fast_fs_e1", 32'(f_fs), 32'd1);
      chk("fast_h_e1", 32'(f_h), 32'd0);
      chk("sm_pix_e1", 32'(s_pix), 32'd0);
      step();
      chk("sm_pix_e2", 32'(s_pix), 32'd1);
      chk("sm_hv_e2", 32'({s_h, s_v}), 32'd0);
      chk("sm_fs_ls_de_e2", 32'({s_fs, s_ls, s_de}), 32'd7);
      chk("def_pix_e2", 32'(d_pix), 32'd0);
      chk("fast_fs_e2", 32'(f_fs), 32'd0);
      chk("fast_h_e2", 32'(f_h), 32'd1);
      step();
      chk("def_pix_e3", 32'(d_pix), 32'd0);
      chk("def_syncs_e3", 32'({d_hs, d_vs}), 32'd3);
      step();
      chk("def_pix_e4", 32'(d_pix), 32'd1);
      chk("def_h_e4", 32'(d_h), 32'd0);
      chk("def_v_e4", 32'(d_v), 32'd0);
      chk("def_de_fs_ls_e4", 32'({d_de, d_fs, d_ls}), 32'd7);
      chk("def_hs_e4", 32'(d_hs), 32'd1);
      chk("sm_h_e4", 32'(s_h), 32'd1);
      chk("sm_ls_e4", 32'(s_ls), 32'd0);
      step();
      chk("def_pix_e5", 32'(d_pix), 32'd0);
      chk("def_h_e5", 32'(d_h), 32'd0);
      chk("def_fs_e5", 32'(d_fs), 32'd0);
   endtask

   initial begin
      int f1, f2, pix, dec, hs_lo, vs_lo, hs_bad, vs_bad, pe_bad, fast_lo, hi, rises, hexp;
      logic prev;
      n_cmp = 0; n_err = 0; cyc = 0;
      f1 = -1; f2 = -1; pix = 0; dec = 0; hs_lo = 0; vs_lo = 0;
      hs_bad = 0; vs_bad = 0; pe_bad = 0; fast_lo = 0; hi = 0; rises = 0;
      rst = 1'b0; en_def = 1'b1; en_sm = 1'b1; en_fast = 1'b1;
      #1 rst = 1'b1;
      #2;
      chk("rst_def_h", 32'(d_h), 32'd799);
      chk("rst_def_v", 32'(d_v), 32'd524);
      chk("rst_def_flags", 32'({d_pix, d_de, d_ls, d_fs}), 32'd0);
      chk("rst_def_syncs", 32'({d_hs, d_vs}), 32'd3);
      chk("rst_def_coords", 32'({d_cc, d_cr, d_gx, d_gy}), 32'd0);
      chk("rst_sm_hv", 32'({s_h, s_v}), 32'({3'd7, 3'd5}));
      chk("rst_fast_syncs", 32'({f_hs, f_vs}), 32'd0);

      release_checks();

      // Small config: two consecutive frame_start pulses bracket one full frame.
      while (f2 < 0 && cyc < 400) begin
         step();
         if (s_pix !== (cyc % 2 == 0)) pe_bad++;
         if (!f_pix) fast_lo++;
         if (f1 >= 0 && s_pix) begin
            pix++;
            if (s_de) dec++;
            if (!s_hs) begin
               hs_lo++;
               if (s_h != 3'd5 && s_h != 3'd6) hs_bad++;
            end
            if (!s_vs) begin
               vs_lo++;
               if (s_v != 3'd4) vs_bad++;
            end
         end
         if (s_fs) begin
            if (f1 < 0) f1 = cyc;
            else f2 = cyc;
         end
      end
      chk("sm_fs_second", 32'(f1), 32'd98);
      chk("sm_fs_spacing", 32'(f2 - f1), 32'd96);
      chk("sm_pixels", 32'(pix), 32'd48);
      chk("sm_de_pixels", 32'(dec), 32'd12);
      chk("sm_hs_low", 32'(hs_lo), 32'd12);
      chk("sm_vs_low", 32'(vs_lo), 32'd8);
      chk("sm_hs_bad", 32'(hs_bad), 32'd0);
      chk("sm_vs_bad", 32'(vs_bad), 32'd0);
      chk("sm_pix_pattern", 32'(pe_bad), 32'd0);

      // Divide-by-1 instance over exactly one 800-clk line.
      prev = f_hs;
      for (int i = 0; i < 800; i++) begin
         step();
         if (f_hs) hi++;
         if (f_hs && !prev) rises++;
         prev = f_hs;
         if (!f_pix) fast_lo++;
      end
      chk("fast_hs_high", 32'(hi), 32'd96);
      chk("fast_hs_runs", 32'(rises), 32'd1);
      chk("fast_pix_low", 32'(fast_lo), 32'd0);

      // Default config: freeze mid-line for 10 clk, two cycles after a tick.
      while (cyc % 4 != 2) step();
      hexp = cyc / 4 - 1;
      en_def = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("en0_pulses", 32'({d_pix, d_ls, d_fs}), 32'd0);
         chk("en0_h", 32'(d_h), 32'(hexp));
      end
      en_def = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reen_pix_early", 32'(d_pix), 32'd0);
      end
      step();
      chk("reen_pix", 32'(d_pix), 32'd1);
      chk("reen_h", 32'(d_h), 32'(hexp + 1));

      // Character-cell decode on the divide-by-1 instance (pixel index = cyc-1).
      while (cyc < 28014) step();
      chk("cc_h13", 32'(f_h), 32'd13);
      chk("cc_v35", 32'(f_v), 32'd35);
      chk("cc_col", 32'(f_cc), 32'd1);
      chk("cc_gx", 32'(f_gx), 32'd5);
      chk("cc_row", 32'(f_cr), 32'd2);
      chk("cc_gy", 32'(f_gy), 32'd3);
      chk("cc_de", 32'(f_de), 32'd1);
      while (cyc < 28640) step();
      chk("cc_h639", 32'(f_h), 32'd639);
      chk("cc_col639", 32'(f_cc), 32'd79);
      chk("cc_gx639", 32'(f_gx), 32'd7);
      chk("cc_de639", 32'(f_de), 32'd1);
      step();
      chk("cc_de640", 32'(f_de), 32'd0);
      chk("cc_coords640", 32'({f_cc, f_cr, f_gx, f_gy}), 32'd0);
      while (cyc < 28651) step();
      chk("cc_h650", 32'(f_h), 32'd650);
      chk("cc_de650", 32'(f_de), 32'd0);
      chk("cc_coords650", 32'({f_cc, f_cr, f_gx, f_gy}), 32'd0);

      // Async reset while the small instance sits in its vsync line.
      while (!(cyc % 2 == 0 && ((cyc / 2 - 1) % 48) == 34) && cyc < 29000) step();
      chk("mid_sm_v", 32'(s_v), 32'd4);
      chk("mid_sm_h", 32'(s_h), 32'd2);
      chk("mid_sm_vs", 32'(s_vs), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_sm_vs", 32'(s_vs), 32'd1);
      chk("mid_rst_sm_hv", 32'({s_h, s_v}), 32'({3'd7, 3'd5}));
      chk("mid_rst_def_h", 32'(d_h), 32'd799);
      chk("mid_rst_fast_flags", 32'({f_pix, f_hs, f_de}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("in_rst_pulses", 32'({d_pix, d_fs, s_pix, s_fs, f_pix, f_fs}), 32'd0);
      end
      release_checks();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
